mode_key_capture: RTL
=====================

# mode_key_capture

Front-end capture block for the trainer's mode-select pushbuttons. Synchronizes and debounces the raw Guest and Auth keys and turns one clean key press into the single-cycle `load_input` strobe plus `usr_ip` mode bit consumed by the user mode-select register. Sits between the board pushbutton pins and the mode-select logic. Rejects bounce, simultaneous presses and keys held through reset.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change and to accept the post-reset quiet period. Legal range is ≥ 2.

Ports:
- `clk`  input  1  system clock; all state is updated on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `btn_guest`  input  1  raw Guest key, asynchronous, high = pressed.
- `btn_auth`  input  1  raw Auth key, asynchronous, high = pressed.
- `load_input`  output  1  one-cycle strobe: a valid mode selection is on `usr_ip`.
- `usr_ip`  output  1  selected mode: 0 = guest, 1 = auth. Holds its value between strobes.
- `conflict`  output  1  one-cycle pulse: both keys were accepted in the same cycle.
- `key_ready`  output  1  high while the FSM is in READY.

## Operation

- **Synchronizer:** each raw key passes through a 2-flop synchronizer (`s1`, `s2`).
- **Debouncer:** one per key, with a stable bit `db` and a counter of width clog2(`DEBOUNCE_CYCLES`).
  - If `s2 == db`, the counter is set to 0.
  - Else, if the counter equals `DEBOUNCE_CYCLES-1`, `db <= s2` and the counter is set to 0.
  - Else, the counter increments.
  - Any reversion before acceptance restarts the count.
- **FSM states:** WAIT_REL, READY, HOLD.
  - **WAIT_REL:**
    - A quiet counter increments while both `s2` and both `db` are 0; otherwise it clears.
    - When it reaches `DEBOUNCE_CYCLES`, go to READY.
  - **READY:**
    - `db_guest=1`, `db_auth=0`: `usr_ip<=0`, `load_input<=1`, go to HOLD.
    - `db_guest=0`, `db_auth=1`: `usr_ip<=1`, `load_input<=1`, go to HOLD.
    - Both 1 in the same cycle: `conflict<=1`. `usr_ip` and `load_input` are unchanged. Go to HOLD.
  - **HOLD:**
    - Wait until `db_guest=0` and `db_auth=0`, then go to READY.
    - A second key pressed while in HOLD is ignored.
- **Outputs:** `load_input` and `conflict` are registered and are high for exactly one cycle per event. They are never both high.
- **Press rule:** READY is entered only with both keys released, so a level seen in READY is a new press. Exactly one strobe is produced per press-release cycle.

## Timing

- **Reset values:**
  - Outputs: `load_input`=0, `usr_ip`=0, `conflict`=0, `key_ready`=0.
  - Internal state: synchronizers, `db` bits and all counters are 0; FSM is in WAIT_REL.
- **Reset assertion:** takes effect immediately and asynchronously, including mid-debounce or during a strobe. A `load_input` pulse in progress is truncated.
- **Reset release:** `key_ready` rises at the edge after `DEBOUNCE_CYCLES` quiet cycles, provided no key is held.
- **Key held through reset:** no strobe is produced until the key is released, debounced low, the quiet period elapses, and the key is pressed again.
- **Press latency** (D = `DEBOUNCE_CYCLES`), counting edges from edge 1, the first edge that samples the raw input high:
  - `s2`=1 after edge 2.
  - `db`=1 after edge D+2.
  - `load_input`=1 for the cycle between edges D+3 and D+4.
  - `usr_ip` is updated at edge D+3 and is valid in the same cycle as the strobe.
- **Release latency:** `db` falls D+2 edges after release; READY is re-entered one edge later.
- **Bounce:** a glitch shorter than D cycles after synchronization produces no change.
- **Near-simultaneous presses:** if the two `db` bits rise on different edges, the first one wins. The second key is ignored in HOLD.

## Test plan

All scenarios use D=4.

- **Reset release, no keys:** `key_ready` rises at edge 4 after reset release. All outputs stay 0.
- **Guest press:** `btn_guest` held high from edge 1 → `load_input`=1 only in the cycle after edge 7, with `usr_ip`=0. Holding for 50 cycles produces no further strobe.
- **Auth press after release:** release, wait 10 cycles, then hold `btn_auth` high → one strobe with `usr_ip`=1. `usr_ip` stays 1 after the strobe.
- **Bounce:** `btn_auth` toggles 1/0 every 2 cycles for 20 cycles, then stays high → exactly one strobe, 7 edges after the final rise, with `usr_ip`=1.
- **Simultaneous press:** both keys rise on the same edge → `conflict`=1 for one cycle. `load_input` stays 0 and `usr_ip` is unchanged.
- **Reset during press:** assert `rst` low mid-debounce with `btn_guest` held; `load_input`=0 immediately. Release reset with the key still held → no strobe. Release the key and press again → one strobe.

Source files
------------

// File: rtl/mode_key_capture.sv
`default_nettype none
// ============================================================================
// Module   : mode_key_capture
// Purpose  : Synchronizes and debounces the Guest/Auth pushbuttons and turns
//            one clean press into a single-cycle load_input strobe carrying the
//            selected mode on usr_ip. Simultaneous presses raise a one-cycle
//            conflict pulse. Keys held through reset are ignored until they
//            have been released.
// Revision : 1.0 - initial release
// ============================================================================
module mode_key_capture #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_guest,
    input  logic btn_auth,
    output logic load_input,
    output logic usr_ip,
    output logic conflict,
    output logic key_ready
);

    // Debounce and quiet-period counters share one width: both count 0..D-1.
    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // Key vectors: bit 0 = guest, bit 1 = auth.
    localparam int c_guest = 0;
    localparam int c_auth  = 1;

    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'd0,
        ST_READY    = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    logic [1:0]              s1_d, s1_q;
    logic [1:0]              s2_d, s2_q;
    logic [1:0]              db_d, db_q;
    logic [1:0][c_cnt_w-1:0] cnt_d, cnt_q;
    logic [c_cnt_w-1:0]      quiet_d, quiet_q;
    state_t                  state_d, state_q;
    logic                    load_d, load_q;
    logic                    usr_d, usr_q;
    logic                    conflict_d, conflict_q;

    // Two-flop synchronizer stage for both raw keys.
    always_comb begin
        s1_d = {btn_auth, btn_guest};
        s2_d = s1_q;
    end

    // Per-key debouncer: accept a new level only after D consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (s2_q[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == c_cnt_max) begin
                db_d[k]  = s2_q[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + c_cnt_one;
            end
        end
    end

    // Mode-select FSM: wait for a quiet period, then emit one event per press.
    always_comb begin
        state_d    = state_q;
        quiet_d    = quiet_q;
        usr_d      = usr_q;
        load_d     = 1'b0;
        conflict_d = 1'b0;
        case (state_q)
            ST_WAIT_REL: begin
                // Both synchronized levels and both debounced levels must be idle.
                if ((s2_q == 2'b00) && (db_q == 2'b00)) begin
                    if (quiet_q == c_cnt_max) begin
                        state_d = ST_READY;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + c_cnt_one;
                    end
                end else begin
                    quiet_d = '0;
                end
            end
            ST_READY: begin
                // READY is only entered with both keys released, so any level here is a new press.
                if (db_q[c_guest] && db_q[c_auth]) begin
                    conflict_d = 1'b1;
                    state_d    = ST_HOLD;
                end else if (db_q[c_guest]) begin
                    usr_d   = 1'b0;
                    load_d  = 1'b1;
                    state_d = ST_HOLD;
                end else if (db_q[c_auth]) begin
                    usr_d   = 1'b1;
                    load_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Anything pressed while holding is ignored until both keys are released.
                if (db_q == 2'b00) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_WAIT_REL;
                quiet_d = '0;
            end
        endcase
    end

    // State register with asynchronous active-low reset; truncates any strobe in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            cnt_q      <= '0;
            quiet_q    <= '0;
            state_q    <= ST_WAIT_REL;
            load_q     <= 1'b0;
            usr_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            quiet_q    <= quiet_d;
            state_q    <= state_d;
            load_q     <= load_d;
            usr_q      <= usr_d;
            conflict_q <= conflict_d;
        end
    end

    assign load_input = load_q;
    assign usr_ip     = usr_q;
    assign conflict   = conflict_q;
    assign key_ready  = (state_q == ST_READY);

endmodule
`default_nettype wire
